// File: rtl/seven_segment_pkg.sv
// Shared definitions for the seven-segment serial shifter: FSM encodings, register
// addresses and chain length derivation.
package seven_segment_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LOAD  = 3'd1;
    localparam logic [2:0] ST_SLOW  = 3'd2;
    localparam logic [2:0] ST_SHIGH = 3'd3;
    localparam logic [2:0] ST_LATCH = 3'd4;

    localparam logic [7:0] ADDR_DATA = 8'h00;
    localparam logic [7:0] ADDR_CTRL = 8'h01;

    function automatic int unsigned nbits(input int unsigned digits);
        return digits * 8;
    endfunction

    localparam int unsigned DEFAULT_DIGITS = 4;
    localparam int unsigned NBITS          = nbits(DEFAULT_DIGITS);

endpackage

// File: rtl/seven_segment_phase_timer.sv
// Phase divider: counts 0..CLK_DIV-1 while enabled and pulses tick on the wrap cycle.
module seven_segment_phase_timer #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clock,
    input  logic resetn,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q;

    assign tick = enable && !clear && (cnt_q == LAST);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (enable) begin
            if (cnt_q == LAST) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/seven_segment_serial_shifter.sv
// Avalon-MM slave that merges writes into a shadow word and shifts it MSB-first into a
// 74HC595-style chain, finishing with a latch strobe; the master is stalled meanwhile.
module seven_segment_serial_shifter
    import seven_segment_pkg::*;
#(
    parameter int unsigned CLK_DIV    = 4,
    parameter int unsigned NUM_DIGITS = 4
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        avs_s0_chipselect,
    input  logic        avs_s0_write,
    input  logic [3:0]  avs_s0_byteenable,
    input  logic [31:0] avs_s0_writedata,
    input  logic [7:0]  avs_s0_address,
    output logic        avs_s0_waitrequest,
    output logic        sr_data,
    output logic        sr_clk,
    output logic        sr_latch,
    output logic        sr_oe_n,
    output logic        busy
);

    localparam int unsigned NB  = nbits(NUM_DIGITS);
    localparam int unsigned BCW = $clog2(NB);

    logic [2:0]     state_q, state_d;
    logic [31:0]    shadow_q;
    logic [31:0]    shift_q;
    logic [BCW-1:0] bitcnt_q;
    logic           sr_data_q, sr_clk_q, sr_latch_q, sr_oe_n_q;
    logic           accept, data_wr, ctrl_wr;
    logic           timer_clear, tick;

    assign accept  = avs_s0_chipselect && avs_s0_write && (state_q == ST_IDLE);
    assign data_wr = accept && (avs_s0_address == ADDR_DATA);
    assign ctrl_wr = accept && (avs_s0_address == ADDR_CTRL);

    // Clearing in IDLE and LOAD makes every following phase exactly CLK_DIV cycles.
    assign timer_clear = (state_q == ST_IDLE) || (state_q == ST_LOAD);

    seven_segment_phase_timer #(
        .CLK_DIV (CLK_DIV)
    ) u_phase_timer (
        .clock  (clock),
        .resetn (resetn),
        .clear  (timer_clear),
        .enable (!timer_clear),
        .tick   (tick)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (data_wr) state_d = ST_LOAD;
            ST_LOAD:  state_d = ST_SLOW;
            ST_SLOW:  if (tick) state_d = ST_SHIGH;
            ST_SHIGH: if (tick) state_d = (bitcnt_q == '0) ? ST_LATCH : ST_SLOW;
            ST_LATCH: if (tick) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q    <= ST_IDLE;
            shadow_q   <= '0;
            sr_oe_n_q  <= 1'b1;
            sr_clk_q   <= 1'b0;
            sr_latch_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            // Strobes follow the next state so they are registered and aligned with it.
            sr_clk_q   <= (state_d == ST_SHIGH);
            sr_latch_q <= (state_d == ST_LATCH);
            if (data_wr) begin
                for (int n = 0; n < 4; n++) begin
                    if (avs_s0_byteenable[n]) shadow_q[8*n +: 8] <= avs_s0_writedata[8*n +: 8];
                end
            end
            if (ctrl_wr && avs_s0_byteenable[0]) begin
                sr_oe_n_q <= avs_s0_writedata[0];
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            shift_q   <= '0;
            bitcnt_q  <= '0;
            sr_data_q <= 1'b0;
        end else if (state_q == ST_LOAD) begin
            shift_q   <= shadow_q;
            bitcnt_q  <= BCW'(NB - 1);
            sr_data_q <= shadow_q[31];
        end else if ((state_q == ST_SHIGH) && tick && (bitcnt_q != '0)) begin
            shift_q   <= {shift_q[30:0], 1'b0};
            bitcnt_q  <= bitcnt_q - 1'b1;
            sr_data_q <= shift_q[30];
        end
    end

    assign avs_s0_waitrequest = (state_q != ST_IDLE);
    assign busy               = (state_q != ST_IDLE);
    assign sr_data            = sr_data_q;
    assign sr_clk             = sr_clk_q;
    assign sr_latch           = sr_latch_q;
    assign sr_oe_n            = sr_oe_n_q;

endmodule

// File: tb/tb_seven_segment_serial_shifter.sv
// Directed bench for seven_segment_serial_shifter: one DUT at CLK_DIV=4, one at CLK_DIV=1.
module tb_seven_segment_serial_shifter;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic        cs0 = 1'b0, cs1 = 1'b0, wr = 1'b0;
    logic [3:0]  be = 4'h0;
    logic [31:0] wd = '0;
    logic [7:0]  addr = 8'h00;
    logic        sel = 1'b0;

    logic wait0, data0, clk0, latch0, oe0, busy0;
    logic wait1, data1, clk1, latch1, oe1, busy1;
    logic m_wait, m_data, m_clk, m_latch;

    int total = 0, passed = 0, failed = 0;

    always #5 clock = ~clock;

    seven_segment_serial_shifter #(.CLK_DIV(4), .NUM_DIGITS(4)) dut (
        .clock(clock), .resetn(resetn), .avs_s0_chipselect(cs0), .avs_s0_write(wr),
        .avs_s0_byteenable(be), .avs_s0_writedata(wd), .avs_s0_address(addr),
        .avs_s0_waitrequest(wait0), .sr_data(data0), .sr_clk(clk0), .sr_latch(latch0),
        .sr_oe_n(oe0), .busy(busy0)
    );

    seven_segment_serial_shifter #(.CLK_DIV(1), .NUM_DIGITS(4)) dut1 (
        .clock(clock), .resetn(resetn), .avs_s0_chipselect(cs1), .avs_s0_write(wr),
        .avs_s0_byteenable(be), .avs_s0_writedata(wd), .avs_s0_address(addr),
        .avs_s0_waitrequest(wait1), .sr_data(data1), .sr_clk(clk1), .sr_latch(latch1),
        .sr_oe_n(oe1), .busy(busy1)
    );

    assign m_wait  = sel ? wait1  : wait0;
    assign m_data  = sel ? data1  : data0;
    assign m_clk   = sel ? clk1   : clk0;
    assign m_latch = sel ? latch1 : latch0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_write(input logic [7:0] a, input logic [3:0] b, input logic [31:0] d);
        int g;
        g = 0;
        @(negedge clock);
        addr = a; be = b; wd = d; wr = 1'b1;
        if (sel) cs1 = 1'b1; else cs0 = 1'b1;
        while (m_wait && g < 2000) begin
            @(negedge clock);
            g++;
        end
        check("write_accept_window", {31'b0, m_wait}, 32'd0);
        @(posedge clock);
        #1;
        cs0 = 1'b0; cs1 = 1'b0; wr = 1'b0;
    endtask

    // Samples once per cycle on the falling edge until busy drops.
    task automatic measure(input int pend_at, input logic [31:0] pend_wd, output int bc,
                           output int rises, output int lat, output logic [31:0] bits);
        logic pc, pl;
        int g;
        bc = 0; rises = 0; lat = 0; bits = '0; pc = 1'b0; pl = 1'b0; g = 0;
        while (g < 3000) begin
            @(negedge clock);
            g++;
            if (!m_wait) break;
            bc++;
            if (bc == pend_at) begin
                addr = 8'h00; be = 4'hF; wd = pend_wd; wr = 1'b1; cs0 = 1'b1;
            end
            if (m_clk && !pc) begin
                rises++;
                bits = {bits[30:0], m_data};
            end
            if (m_latch && !pl) lat++;
            pc = m_clk;
            pl = m_latch;
        end
        check("xfer_done", {31'b0, m_wait}, 32'd0);
    endtask

    initial begin
        int bc, rises, lat, g, acc;
        logic [31:0] bits;
        logic pc;

        // Reset values
        repeat (3) @(negedge clock);
        check("rst_waitreq", {31'b0, wait0}, 32'd0);
        check("rst_busy", {31'b0, busy0}, 32'd0);
        check("rst_sr_bits", {28'b0, data0, clk0, latch0, oe0}, 32'h1);
        resetn = 1'b1;

        // 1: full transfer with all lanes
        do_write(8'h00, 4'hF, 32'hA5C3_0F81);
        measure(-1, '0, bc, rises, lat, bits);
        check("t1_busy_cycles", bc, 32'd261);
        check("t1_clk_rises", rises, 32'd32);
        check("t1_bits", bits, 32'hA5C3_0F81);
        check("t1_latches", lat, 32'd1);
        check("t1_latch_low_idle", {31'b0, latch0}, 32'd0);

        // 2: byteenable merge
        do_write(8'h00, 4'hF, 32'h1122_3344);
        measure(-1, '0, bc, rises, lat, bits);
        check("t2a_bits", bits, 32'h1122_3344);
        do_write(8'h00, 4'b0010, 32'hFFFF_FFFF);
        measure(-1, '0, bc, rises, lat, bits);
        check("t2b_bits", bits, 32'h1122_FF44);
        check("t2b_clk_rises", rises, 32'd32);

        // 3: second write held by waitrequest
        do_write(8'h00, 4'hF, 32'h0F0F_3C3C);
        measure(5, 32'h8001_7FFE, bc, rises, lat, bits);
        check("t3a_busy_cycles", bc, 32'd261);
        check("t3a_bits", bits, 32'h0F0F_3C3C);
        check("t3a_clk_rises", rises, 32'd32);
        check("t3a_latches", lat, 32'd1);
        @(posedge clock);
        #1;
        check("t3_accepted_first_idle", {31'b0, wait0}, 32'd1);
        cs0 = 1'b0; wr = 1'b0;
        measure(-1, '0, bc, rises, lat, bits);
        check("t3b_busy_cycles", bc, 32'd261);
        check("t3b_bits", bits, 32'h8001_7FFE);

        // 4: CTRL and ignored addresses
        check("t4_oe_before", {31'b0, oe0}, 32'd1);
        do_write(8'h01, 4'h1, 32'h0000_0000);
        check("t4_oe_after", {31'b0, oe0}, 32'd0);
        check("t4_no_stall", {31'b0, wait0}, 32'd0);
        do_write(8'h01, 4'h0, 32'h0000_0001);
        do_write(8'h05, 4'hF, 32'hFFFF_FFFF);
        acc = 0;
        repeat (12) begin
            @(negedge clock);
            acc = acc + int'(clk0) + int'(wait0) + int'(latch0);
        end
        check("t4_oe_be0_kept", {31'b0, oe0}, 32'd0);
        check("t4_no_activity", acc, 32'd0);

        // 5: asynchronous reset at bit 10
        do_write(8'h00, 4'hF, 32'hA5C3_0F81);
        rises = 0; pc = 1'b0; g = 0;
        while (rises < 10 && g < 2000) begin
            @(negedge clock);
            g++;
            if (clk0 && !pc) rises++;
            pc = clk0;
        end
        check("t5_reached_bit10", rises, 32'd10);
        #1 resetn = 1'b0;
        #1;
        check("t5_rst_waitreq", {31'b0, wait0}, 32'd0);
        check("t5_rst_busy", {31'b0, busy0}, 32'd0);
        check("t5_rst_sr_bits", {28'b0, data0, clk0, latch0, oe0}, 32'h1);
        check("t5_rst_shadow", dut.shadow_q, 32'd0);
        @(negedge clock);
        resetn = 1'b1;
        do_write(8'h00, 4'b0001, 32'h1234_5678);
        measure(-1, '0, bc, rises, lat, bits);
        check("t5_post_busy", bc, 32'd261);
        check("t5_post_bits", bits, 32'h0000_0078);
        check("t5_post_latches", lat, 32'd1);

        // 6: CLK_DIV=1 and byteenable=0 re-send
        sel = 1'b1;
        do_write(8'h00, 4'hF, 32'hDEAD_BEEF);
        measure(-1, '0, bc, rises, lat, bits);
        check("t6a_busy_cycles", bc, 32'd66);
        check("t6a_bits", bits, 32'hDEAD_BEEF);
        do_write(8'h00, 4'h0, 32'h0000_0000);
        measure(-1, '0, bc, rises, lat, bits);
        check("t6b_busy_cycles", bc, 32'd66);
        check("t6b_bits", bits, 32'hDEAD_BEEF);
        check("t6b_clk_rises", rises, 32'd32);
        check("t6b_latches", lat, 32'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
